demux_pack: RTL



---
 rtl/demux_pack_pkg.sv | 14 +
 rtl/demux_pack.sv | 91 +++++++++
 2 files changed

// File: rtl/demux_pack_pkg.sv
// Shared definitions for the serial-to-parallel word collector.
// Holds the state encoding and the slot-count helper.
package demux_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int num_slots(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/demux_pack.sv
// Collects a stream of size-bit words into 2**n slots of a packed bus and
// offers the completed bus downstream under a valid/ready handshake.
module demux_pack
  import demux_pack_pkg::*;
#(
  parameter int size = 4,
  parameter int n = 3,
  localparam int NUM_SLOTS = num_slots(n),
  // A zero-width slot index is not expressible; n=0 uses one constant-zero bit.
  localparam int SW = (n > 0) ? n : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [size-1:0]           in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [size*NUM_SLOTS-1:0] out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SW-1:0]             slot
);

  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);

  state_t                      state_reg;
  state_t                      state_next;
  logic [SW-1:0]               slot_reg;
  logic [SW-1:0]               slot_next;
  logic [size*NUM_SLOTS-1:0]   out_reg;
  logic                        accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FILL;
      slot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    accept     = 1'b0;
    if (clear) begin
      state_next = FILL;
      slot_next  = '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (in_valid) begin
            accept = 1'b1;
            if (slot_reg == LAST_SLOT) begin
              state_next = HOLD;
              slot_next  = '0;
            end else begin
              slot_next = slot_reg + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_next = FILL;
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  // Only the addressed slot is written; other slots keep the previous frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (accept && (slot_reg == SW'(i))) begin
          out_reg[i*size +: size] <= in_data;
        end
      end
    end
  end

  assign in_ready  = (state_reg == FILL);
  assign out_valid = (state_reg == HOLD);
  assign out       = out_reg;
  assign slot      = slot_reg;

endmodule
